// File: rtl/multi_port_slot_allocator_pkg.sv
// Shared defaults and types for the multi-port slot allocator.
package slot_alloc_pkg;

  localparam int DEF_DEPTH       = 64;
  localparam int DEF_ALLOC_PORTS = 3;
  localparam int DEF_FREE_PORTS  = 3;
  localparam int DEF_RESERVED    = 0;
  localparam int DEF_IDX_W       = $clog2(DEF_DEPTH);

  typedef logic [DEF_IDX_W-1:0]       slot_idx_t;
  typedef logic [DEF_ALLOC_PORTS-1:0] alloc_vec_t;

  // Index width needed to address a free map of the given depth.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/multi_port_slot_allocator_if.sv
// Allocation / release bus of the slot allocator. The front end drives it
// through the master modport, the allocator serves it through slave.
import slot_alloc_pkg::*;

interface multi_port_slot_allocator_if #(
  parameter int ALLOC_PORTS = DEF_ALLOC_PORTS,
  parameter int FREE_PORTS  = DEF_FREE_PORTS,
  parameter int IDX_W       = DEF_IDX_W
);
  logic                         flush;
  logic [ALLOC_PORTS-1:0]       alloc_req;
  logic [ALLOC_PORTS-1:0]       alloc_gnt;
  logic [ALLOC_PORTS*IDX_W-1:0] alloc_idx;
  logic [FREE_PORTS-1:0]        free_valid;
  logic [FREE_PORTS*IDX_W-1:0]  free_idx;
  logic [IDX_W:0]               free_count;
  logic                         empty;
  logic                         can_alloc_all;

  modport master (
    output flush, alloc_req, free_valid, free_idx,
    input  alloc_gnt, alloc_idx, free_count, empty, can_alloc_all
  );

  modport slave (
    input  flush, alloc_req, free_valid, free_idx,
    output alloc_gnt, alloc_idx, free_count, empty, can_alloc_all
  );
endinterface

// File: rtl/multi_port_slot_allocator_chk.sv
// Simulation checks for the slot allocator: the registered count must always
// equal the population of the free map, and releases of entries that are
// already free or reserved are tallied in illegal_free_cnt (they are ignored
// by the datapath).
module multi_port_slot_allocator_chk #(
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6,
  parameter int FREE_PORTS = 3,
  parameter int RESERVED   = 0
) (
  input logic                        clk,
  input logic                        reset,
  input logic [DEPTH-1:0]            i_free_map,
  input logic [IDX_W:0]              i_free_count,
  input logic [FREE_PORTS-1:0]       i_free_valid,
  input logic [FREE_PORTS*IDX_W-1:0] i_free_idx
);

  function automatic logic [DEPTH-1:0] reset_map();
    logic [DEPTH-1:0] m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (i >= RESERVED);
    end
    return m;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  localparam logic [DEPTH-1:0] L_RESET_MAP = reset_map();

  int w_illegal_n;
  int illegal_free_cnt;

  // Count release ports naming an entry that is already free or reserved.
  always_comb begin
    w_illegal_n = 0;
    for (int f = 0; f < FREE_PORTS; f++) begin
      w_illegal_n = w_illegal_n + int'(i_free_valid[f] &
                    (i_free_map[i_free_idx[f*IDX_W +: IDX_W]] |
                     ~L_RESET_MAP[i_free_idx[f*IDX_W +: IDX_W]]));
    end
  end

  // Accumulate illegal releases and check the count/map invariant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_free_cnt <= 0;
    end else begin
      illegal_free_cnt <= illegal_free_cnt + w_illegal_n;
      assert (i_free_count == popcount(i_free_map));
    end
  end

endmodule

// File: rtl/multi_port_slot_allocator_lsb_multi_pick.sv
// Combinational picker: returns the PICKS lowest set-bit positions of a
// vector, lowest first, by repeatedly taking the lowest bit and masking it.
module lsb_multi_pick #(
  parameter int WIDTH = 64,
  parameter int PICKS = 3,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]       i_vec,
  output logic [PICKS*IDX_W-1:0] o_idx,
  output logic [PICKS-1:0]       o_valid
);

  logic [WIDTH-1:0] w_rem;

  // Peel off the lowest remaining set bit once per pick slot.
  always_comb begin
    w_rem   = i_vec;
    o_idx   = '0;
    o_valid = '0;
    for (int p = 0; p < PICKS; p++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_rem[i] && !o_valid[p]) begin
          o_valid[p]                = 1'b1;
          o_idx[p*IDX_W +: IDX_W]   = IDX_W'(i);
          w_rem[i]                  = 1'b0;
        end else begin
          w_rem[i] = w_rem[i];
        end
      end
    end
  end

endmodule

// File: rtl/multi_port_slot_allocator.sv
// Registered free-list allocator. Keeps a DEPTH-bit free map, grants up to
// ALLOC_PORTS lowest free entries per cycle (requesting ports compacted in
// port order) and accepts up to FREE_PORTS releases per cycle.
// Optional macro SLOT_ALLOC_FREE_BYPASS_EN: entries released this cycle are
// also grantable this cycle; otherwise released entries become grantable on
// the following cycle and there is no combinational path free_* -> alloc_*.
import slot_alloc_pkg::*;

module multi_port_slot_allocator #(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int IDX_W       = idx_width(DEPTH),
  parameter int ALLOC_PORTS = DEF_ALLOC_PORTS,
  parameter int FREE_PORTS  = DEF_FREE_PORTS,
  parameter int RESERVED    = DEF_RESERVED
) (
  input logic                      clk,
  input logic                      reset,
  multi_port_slot_allocator_if.slave bus
);

  function automatic logic [DEPTH-1:0] reset_map();
    logic [DEPTH-1:0] m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (i >= RESERVED);
    end
    return m;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  localparam logic [DEPTH-1:0] L_RESET_MAP   = reset_map();
  localparam logic [IDX_W:0]   L_RESET_COUNT = (IDX_W+1)'(DEPTH - RESERVED);
  localparam logic [IDX_W:0]   L_PORTS_COUNT = (IDX_W+1)'(ALLOC_PORTS);

  logic [DEPTH-1:0]             r_free_map;
  logic [IDX_W:0]               r_free_count;
  logic                         r_empty;
  logic                         r_can_alloc_all;

  logic [DEPTH-1:0]             w_freed_mask;
  logic [DEPTH-1:0]             w_pick_vec;
  logic [ALLOC_PORTS*IDX_W-1:0] w_pick_idx;
  logic [ALLOC_PORTS-1:0]       w_pick_valid;
  logic [ALLOC_PORTS-1:0]       w_gnt;
  logic [ALLOC_PORTS*IDX_W-1:0] w_idx;
  logic [DEPTH-1:0]             w_gnt_mask;
  logic                         w_sel_valid;
  logic [IDX_W-1:0]             w_sel_idx;
  logic [DEPTH-1:0]             w_next_map;
  logic [IDX_W:0]               w_next_count;
  int                           w_rank;

  // Decode releases into a mask; duplicates collapse, illegal ones drop out.
  always_comb begin
    w_freed_mask = '0;
    for (int f = 0; f < FREE_PORTS; f++) begin
      w_freed_mask[bus.free_idx[f*IDX_W +: IDX_W]] =
        w_freed_mask[bus.free_idx[f*IDX_W +: IDX_W]] |
        (bus.free_valid[f] &
         L_RESET_MAP[bus.free_idx[f*IDX_W +: IDX_W]] &
         ~r_free_map[bus.free_idx[f*IDX_W +: IDX_W]]);
    end
  end

`ifdef SLOT_ALLOC_FREE_BYPASS_EN
  assign w_pick_vec = r_free_map | w_freed_mask;
`else
  assign w_pick_vec = r_free_map;
`endif

  lsb_multi_pick #(
    .WIDTH (DEPTH),
    .PICKS (ALLOC_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_vec   (w_pick_vec),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Map requesting ports onto consecutive pick slots in port order.
  always_comb begin
    w_rank      = 0;
    w_gnt       = '0;
    w_idx       = '0;
    w_gnt_mask  = '0;
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int p = 0; p < ALLOC_PORTS; p++) begin
      w_sel_valid = 1'b0;
      w_sel_idx   = '0;
      for (int k = 0; k < ALLOC_PORTS; k++) begin
        if (k == w_rank) begin
          w_sel_valid = w_pick_valid[k];
          w_sel_idx   = w_pick_idx[k*IDX_W +: IDX_W];
        end else begin
          w_sel_valid = w_sel_valid;
        end
      end
      w_gnt[p] = bus.alloc_req[p] & w_sel_valid & ~bus.flush & reset;
      if (w_gnt[p]) begin
        w_idx[p*IDX_W +: IDX_W] = w_sel_idx;
        w_gnt_mask[w_sel_idx]   = 1'b1;
      end else begin
        w_idx[p*IDX_W +: IDX_W] = '0;
      end
      w_rank = w_rank + int'(bus.alloc_req[p]);
    end
  end

  // A bypassed entry is both freed and granted, so it nets out of the map.
  assign w_next_map   = (r_free_map | w_freed_mask) & ~w_gnt_mask;
  assign w_next_count = r_free_count - popcount(w_gnt_mask) + popcount(w_freed_mask);

  // Free map, count and the count-derived status flags; flush restores reset contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_free_map      <= L_RESET_MAP;
      r_free_count    <= L_RESET_COUNT;
      r_empty         <= (L_RESET_COUNT == '0);
      r_can_alloc_all <= (L_RESET_COUNT >= L_PORTS_COUNT);
    end else if (bus.flush) begin
      r_free_map      <= L_RESET_MAP;
      r_free_count    <= L_RESET_COUNT;
      r_empty         <= (L_RESET_COUNT == '0);
      r_can_alloc_all <= (L_RESET_COUNT >= L_PORTS_COUNT);
    end else begin
      r_free_map      <= w_next_map;
      r_free_count    <= w_next_count;
      r_empty         <= (w_next_count == '0);
      r_can_alloc_all <= (w_next_count >= L_PORTS_COUNT);
    end
  end

  assign bus.alloc_gnt     = w_gnt;
  assign bus.alloc_idx     = w_idx;
  assign bus.free_count    = r_free_count;
  assign bus.empty         = r_empty;
  assign bus.can_alloc_all = r_can_alloc_all;

  multi_port_slot_allocator_chk #(
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W),
    .FREE_PORTS (FREE_PORTS),
    .RESERVED   (RESERVED)
  ) u_chk (
    .clk          (clk),
    .reset        (reset),
    .i_free_map   (r_free_map),
    .i_free_count (r_free_count),
    .i_free_valid (bus.free_valid),
    .i_free_idx   (bus.free_idx)
  );

endmodule

// File: tb/tb_multi_port_slot_allocator.sv
// Directed bench for multi_port_slot_allocator: one instance with no reserved
// entries and one with 32 reserved entries, 64 deep, 3 alloc / 3 free ports.
module tb_multi_port_slot_allocator;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multi_port_slot_allocator_if #(.ALLOC_PORTS(3), .FREE_PORTS(3), .IDX_W(6)) if0 ();
  multi_port_slot_allocator_if #(.ALLOC_PORTS(3), .FREE_PORTS(3), .IDX_W(6)) if1 ();

  multi_port_slot_allocator #(
    .DEPTH(64), .IDX_W(6), .ALLOC_PORTS(3), .FREE_PORTS(3), .RESERVED(0)
  ) dut0 (.clk(clk), .reset(rst_n), .bus(if0));

  multi_port_slot_allocator #(
    .DEPTH(64), .IDX_W(6), .ALLOC_PORTS(3), .FREE_PORTS(3), .RESERVED(32)
  ) dut1 (.clk(clk), .reset(rst_n), .bus(if1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] pack(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    return {c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic free0(input logic [2:0] v, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    if0.free_valid = v;
    if0.free_idx   = pack(a, b, c);
  endtask

  initial begin
    if0.flush = 1'b0; if0.alloc_req = 3'b111; if0.free_valid = 3'b000; if0.free_idx = 18'd0;
    if1.flush = 1'b0; if1.alloc_req = 3'b000; if1.free_valid = 3'b000; if1.free_idx = 18'd0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_count0", 64'(if0.free_count), 64'd64);
    chk("rst_empty0", 64'(if0.empty), 64'd0);
    chk("rst_canall0", 64'(if0.can_alloc_all), 64'd1);
    chk("rst_gnt0", 64'(if0.alloc_gnt), 64'd0);
    chk("rst_idx0", 64'(if0.alloc_idx), 64'd0);
    chk("rst_count1", 64'(if1.free_count), 64'd32);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // T1: first grants 0,1,2 then 3,4,5
    if0.alloc_req = 3'b111; #1;
    chk("t1_gnt", 64'(if0.alloc_gnt), 64'b111);
    chk("t1_idx", 64'(if0.alloc_idx), 64'(pack(6'd0, 6'd1, 6'd2)));
    tick();
    chk("t1_count", 64'(if0.free_count), 64'd61);
    chk("t1_gnt2", 64'(if0.alloc_gnt), 64'b111);
    chk("t1_idx2", 64'(if0.alloc_idx), 64'(pack(6'd3, 6'd4, 6'd5)));
    tick();
    if0.alloc_req = 3'b000;
    chk("t1_count2", 64'(if0.free_count), 64'd58);
    free0(3'b111, 6'd0, 6'd1, 6'd2); tick();
    free0(3'b111, 6'd3, 6'd4, 6'd5); tick();
    free0(3'b000, 6'd0, 6'd0, 6'd0);
    chk("t1_restore", 64'(if0.free_count), 64'd64);

    // T3: sparse request, non-requesting port consumes nothing
    if0.alloc_req = 3'b101; #1;
    chk("t3_gnt", 64'(if0.alloc_gnt), 64'b101);
    chk("t3_idx", 64'(if0.alloc_idx), 64'(pack(6'd0, 6'd0, 6'd1)));
    tick();
    if0.alloc_req = 3'b000;
    chk("t3_count", 64'(if0.free_count), 64'd62);
    free0(3'b011, 6'd0, 6'd1, 6'd0); tick();
    free0(3'b000, 6'd0, 6'd0, 6'd0);
    chk("t3_restore", 64'(if0.free_count), 64'd64);

    // T4: duplicate release counted once, re-release ignored
    if0.alloc_req = 3'b111; tick(); tick();
    if0.alloc_req = 3'b000;
    chk("t4_count58", 64'(if0.free_count), 64'd58);
    free0(3'b111, 6'd0, 6'd1, 6'd2); tick();
    free0(3'b011, 6'd3, 6'd4, 6'd0); tick();
    chk("t4_count63", 64'(if0.free_count), 64'd63);
    free0(3'b011, 6'd5, 6'd5, 6'd0); tick();
    chk("t4_dup_once", 64'(if0.free_count), 64'd64);
    chk("t4_illegal0", 64'(dut0.u_chk.illegal_free_cnt), 64'd0);
    free0(3'b001, 6'd5, 6'd0, 6'd0); tick();
    free0(3'b000, 6'd0, 6'd0, 6'd0);
    chk("t4_refree_ignored", 64'(if0.free_count), 64'd64);
    chk("t4_illegal1", 64'(dut0.u_chk.illegal_free_cnt), 64'd1);

    // T2: drain the map, then leave only 7 and 40 free
    if0.alloc_req = 3'b111;
    repeat (21) tick();
    if0.alloc_req = 3'b001; tick();
    if0.alloc_req = 3'b000;
    chk("t2_drain_count", 64'(if0.free_count), 64'd0);
    chk("t2_drain_empty", 64'(if0.empty), 64'd1);
    chk("t2_drain_canall", 64'(if0.can_alloc_all), 64'd0);
    if0.alloc_req = 3'b111; #1;
    chk("t2_empty_gnt", 64'(if0.alloc_gnt), 64'd0);
    if0.alloc_req = 3'b000;
    free0(3'b011, 6'd7, 6'd40, 6'd0); tick();
    free0(3'b000, 6'd0, 6'd0, 6'd0);
    chk("t2_two_count", 64'(if0.free_count), 64'd2);
    chk("t2_two_canall", 64'(if0.can_alloc_all), 64'd0);
    chk("t2_two_empty", 64'(if0.empty), 64'd0);
    if0.alloc_req = 3'b111; #1;
    chk("t2_gnt", 64'(if0.alloc_gnt), 64'b011);
    chk("t2_idx", 64'(if0.alloc_idx), 64'(pack(6'd7, 6'd40, 6'd0)));
    tick();
    if0.alloc_req = 3'b000;
    chk("t2_count", 64'(if0.free_count), 64'd0);
    chk("t2_empty", 64'(if0.empty), 64'd1);

    // T5: release into an empty map with a simultaneous request
    free0(3'b001, 6'd9, 6'd0, 6'd0);
    if0.alloc_req = 3'b001; #1;
`ifdef SLOT_ALLOC_FREE_BYPASS_EN
    chk("t5_byp_gnt", 64'(if0.alloc_gnt), 64'b001);
    chk("t5_byp_idx", 64'(if0.alloc_idx), 64'(pack(6'd9, 6'd0, 6'd0)));
    tick();
    free0(3'b000, 6'd0, 6'd0, 6'd0);
    if0.alloc_req = 3'b000;
    chk("t5_byp_count", 64'(if0.free_count), 64'd0);
    chk("t5_byp_empty", 64'(if0.empty), 64'd1);
`else
    chk("t5_gnt", 64'(if0.alloc_gnt), 64'b000);
    chk("t5_idx", 64'(if0.alloc_idx), 64'd0);
    tick();
    free0(3'b000, 6'd0, 6'd0, 6'd0);
    chk("t5_count1", 64'(if0.free_count), 64'd1);
    chk("t5_gnt_next", 64'(if0.alloc_gnt), 64'b001);
    chk("t5_idx_next", 64'(if0.alloc_idx), 64'(pack(6'd9, 6'd0, 6'd0)));
    tick();
    if0.alloc_req = 3'b000;
    chk("t5_count0", 64'(if0.free_count), 64'd0);
`endif

    // T6: reserved entries, illegal reserved release, flush
    if1.alloc_req = 3'b111; #1;
    chk("t6_gnt", 64'(if1.alloc_gnt), 64'b111);
    chk("t6_idx", 64'(if1.alloc_idx), 64'(pack(6'd32, 6'd33, 6'd34)));
    tick(); tick(); tick();
    if1.alloc_req = 3'b001; tick();
    if1.alloc_req = 3'b000;
    chk("t6_count22", 64'(if1.free_count), 64'd22);
    if1.free_valid = 3'b001; if1.free_idx = pack(6'd3, 6'd0, 6'd0); tick();
    if1.free_valid = 3'b000;
    chk("t6_reserved_ignored", 64'(if1.free_count), 64'd22);
    chk("t6_illegal1", 64'(dut1.u_chk.illegal_free_cnt), 64'd1);
    if1.flush = 1'b1; if1.alloc_req = 3'b111; #1;
    chk("t6_flush_gnt", 64'(if1.alloc_gnt), 64'b000);
    tick();
    if1.flush = 1'b0; if1.alloc_req = 3'b000;
    chk("t6_flush_count", 64'(if1.free_count), 64'd32);
    if1.alloc_req = 3'b001; #1;
    chk("t6_first_after_flush", 64'(if1.alloc_idx), 64'(pack(6'd32, 6'd0, 6'd0)));
    if1.alloc_req = 3'b000;

    // Asynchronous reset in the middle of a cycle
    if0.alloc_req = 3'b111;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count0", 64'(if0.free_count), 64'd64);
    chk("arst_gnt0", 64'(if0.alloc_gnt), 64'd0);
    chk("arst_empty0", 64'(if0.empty), 64'd0);
    chk("arst_count1", 64'(if1.free_count), 64'd32);
    #3 rst_n = 1'b1;
    #1;
    chk("arst_regrant", 64'(if0.alloc_idx), 64'(pack(6'd0, 6'd1, 6'd2)));
    if0.alloc_req = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
